bp_sink_mc: RTL and testbench
=============================

Name: bp_sink_mc

Overview:
- Multi-channel valid/ready sink used as a configurable back-pressure target in monitor/driver testbenches.
- Each channel accepts transfers and can deassert ready in one of four modes:
  - always-ready
  - LFSR-random stall, with programmable probability and maximum length
  - fixed deterministic stall after every transfer
  - hard hold
- Each channel keeps a transfer count and a data checksum so the bench can cross-check its monitor scoreboard.

Parameters:
- NUM_CH, 4: number of independent valid/ready channels.
- DATA_W, 8: data width per channel.
- STALL_W, 3: width of the stall-length counter. Maximum stall is 2^STALL_W-1 cycles.
- SEED, 16'hACE1: base LFSR seed. Channel i seed = SEED ^ (i*16'h1111). A seed that evaluates to zero is replaced by 16'h0001.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- valid, input, NUM_CH: per-channel valid.
- data, input, NUM_CH*DATA_W: channel i occupies bits [i*DATA_W +: DATA_W].
- ready, output, NUM_CH: per-channel ready.
- mode, input, 2: 0=ALWAYS, 1=RANDOM, 2=FIXED, 3=HOLD. Common to all channels.
- thresh, input, 8: in RANDOM mode a stall is triggered when rand_8 > thresh.
- max_stall, input, STALL_W: stall length cap in RANDOM mode; exact stall length in FIXED mode.
- clear, input, 1: synchronous clear of all counts and checksums.
- xfer_cnt, output, NUM_CH*16: per-channel accepted-transfer count.
- csum, output, NUM_CH*DATA_W: per-channel sum of accepted data, modulo 2^DATA_W.

Behaviour:
- Transfer condition: xfer[i] = valid[i] & ready[i] at a rising edge. A valid that is low is never counted.
- Per-channel LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle regardless of mode; reloads its seed on reset.
  - rand_8 = lfsr[7:0].
- Per-channel FSM, states RDY and STALL, with a counter cnt[STALL_W-1:0]:
  - ready[i] = (state==RDY) && (mode!=HOLD). This is combinational from registered state and the mode input.
  - RDY, RANDOM mode: on xfer with rand_8 > thresh and max_stall != 0, go to STALL. cnt loads L, where L = rand_8[STALL_W-1:0]; 0 maps to 1; values > max_stall clip to max_stall.
  - RDY, FIXED mode: on every xfer with max_stall != 0, go to STALL with cnt = max_stall.
  - STALL: ready low. cnt decrements each cycle; when cnt==1, return to RDY next edge. The stall therefore lasts exactly L cycles, and ready is high again on cycle L+1 after the transfer.
  - Mode ALWAYS or HOLD: FSM is forced to RDY with cnt=0 on the next edge. Any stall in progress is aborted.
  - Changing between RANDOM and FIXED mid-stall lets the current stall complete unchanged.
- Thresholds and stall lengths are sampled only at the triggering transfer.
  - thresh=255 means RANDOM never stalls.
  - max_stall=0 disables stalls in both RANDOM and FIXED.
- Counters:
  - On xfer, xfer_cnt[i] increments (16-bit, wraps 16'hFFFF to 0) and csum[i] += data[i] (wraps).
  - clear has priority: a transfer coincident with clear is not counted and the result is 0.
  - Transfers and stalls are still accepted during clear.
- Reset (rst_n low at a clock edge):
  - FSM goes to RDY with cnt=0; xfer_cnt=0, csum=0; LFSRs reload their seeds.
  - ready = 1 for modes 0–2 and 0 for HOLD.
  - Reset during a stall aborts it; ready is high on the cycle after reset is released.
- Channels are fully independent; only mode, thresh, max_stall and clear are shared.
- Latency: a stall decision is made on the accepting edge and ready falls in the following cycle. No combinational path exists from valid to ready.

Test Plan:
- Reset, mode=0, all valid=1 for 100 cycles, data=8'h01 -> ready stays at 4'hF; each xfer_cnt=100, each csum=8'h64.
- mode=2, max_stall=3, valid held on ch0 for 40 cycles -> ready pattern is 1,0,0,0 repeating; xfer_cnt[0]=10.
- mode=1, thresh=255, 1000 cycles -> zero stalls. Then thresh=0, max_stall=7 -> a stall after every transfer, each 1–7 cycles long, never more than 7; the bench models the LFSR and checks the exact sequence.
- mode=2, max_stall=5, switch to mode=3 in the 2nd stall cycle -> ready=0 throughout; switch to mode=0 -> ready=1 on the next cycle with no leftover stall.
- clear asserted in the same cycle as a ch1 transfer, after 20 counted transfers -> xfer_cnt[1]=0 and csum[1]=0 the next cycle; the following transfer reads 1.
- rst_n low for one edge during a 7-cycle FIXED stall -> ready=1 the cycle after release; counters=0; LFSR output equals the post-seed sequence again.

Source files
------------

// File: rtl/bp_sink_mc_if.sv
// Purpose : valid/ready bundle for the multi-channel back-pressure sink.
// Ports   : valid[NUM_CH], data[NUM_CH*DATA_W] (channel i at [i*DATA_W +: DATA_W]),
//           ready[NUM_CH]. master drives valid/data, slave drives ready.
interface bp_sink_mc_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0]        valid;
  logic [NUM_CH*DATA_W-1:0] data;
  logic [NUM_CH-1:0]        ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bp_sink_mc.sv
// Purpose : multi-channel valid/ready sink with selectable back-pressure
//           (always-ready, LFSR-random stall, fixed stall, hard hold), plus
//           per-channel transfer counts and data checksums.
// Latency : stall decision taken on the accepting edge; ready falls the next cycle.
// Backpr. : ready depends only on registered state and mode_i, never on valid.
// Ports   : clk_i, rst_n_i (sync, active low); snk_if (slave: valid/data in, ready out);
//           mode_i, thresh_i, max_stall_i, clear_i shared by all channels;
//           xfer_cnt_o[NUM_CH*16], csum_o[NUM_CH*DATA_W] per channel.
module bp_sink_mc #(
  parameter int          NUM_CH  = 4,
  parameter int          DATA_W  = 8,
  parameter int          STALL_W = 3,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  bp_sink_mc_if.slave               snk_if,
  input  logic [1:0]                mode_i,
  input  logic [7:0]                thresh_i,
  input  logic [STALL_W-1:0]        max_stall_i,
  input  logic                      clear_i,
  output logic [NUM_CH*16-1:0]      xfer_cnt_o,
  output logic [NUM_CH*DATA_W-1:0]  csum_o
);

  localparam logic [1:0] M_ALWAYS = 2'd0;
  localparam logic [1:0] M_RANDOM = 2'd1;
  localparam logic [1:0] M_FIXED  = 2'd2;
  localparam logic [1:0] M_HOLD   = 2'd3;

  typedef enum logic {S_RDY, S_STALL} state_e;

  logic [NUM_CH-1:0] ready_vec;
  assign snk_if.ready = ready_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Distinct seed per channel; an all-zero LFSR would lock up.
    localparam logic [15:0] SEED_RAW = SEED ^ (16'(i) * 16'h1111);
    localparam logic [15:0] SEED_CH  = (SEED_RAW == 16'h0000) ? 16'h0001 : SEED_RAW;

    state_e              state_q;
    logic [STALL_W-1:0]  cnt_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         lfsr_d;
    logic [15:0]         xcnt_q;
    logic [DATA_W-1:0]   csum_q;
    logic [7:0]          rand8;
    logic [STALL_W-1:0]  len_d;
    logic                rdy;
    logic                xfer;
    logic                force_rdy;

    assign rand8  = lfsr_q[7:0];
    // Fibonacci, taps 16,14,13,11 (1-based) shifting toward the MSB.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    assign rdy          = (state_q == S_RDY) && (mode_i != M_HOLD);
    assign ready_vec[i] = rdy;
    assign xfer         = snk_if.valid[i] & rdy;
    assign force_rdy    = (mode_i == M_ALWAYS) || (mode_i == M_HOLD);

    // Random stall length: low LFSR bits, zero promoted to one, clipped to max_stall.
    always_comb begin
      len_d = rand8[STALL_W-1:0];
      if (len_d == '0) len_d = STALL_W'(1);
      if (len_d > max_stall_i) len_d = max_stall_i;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        state_q <= S_RDY;
        cnt_q   <= '0;
        lfsr_q  <= SEED_CH;
        xcnt_q  <= '0;
        csum_q  <= '0;
      end else begin
        lfsr_q <= lfsr_d;

        // clear wins over a coincident transfer.
        if (clear_i) begin
          xcnt_q <= '0;
          csum_q <= '0;
        end else if (xfer) begin
          xcnt_q <= xcnt_q + 16'd1;
          csum_q <= csum_q + snk_if.data[i*DATA_W +: DATA_W];
        end

        if (force_rdy) begin
          // ALWAYS/HOLD abort any stall in progress.
          state_q <= S_RDY;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            S_RDY: begin
              if (xfer && (max_stall_i != '0)) begin
                if (mode_i == M_RANDOM) begin
                  if (rand8 > thresh_i) begin
                    state_q <= S_STALL;
                    cnt_q   <= len_d;
                  end
                end else if (mode_i == M_FIXED) begin
                  state_q <= S_STALL;
                  cnt_q   <= max_stall_i;
                end
              end
            end
            S_STALL: begin
              // A stall of length L spends exactly L cycles here.
              if (cnt_q <= STALL_W'(1)) begin
                state_q <= S_RDY;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q - STALL_W'(1);
              end
            end
            default: begin
              state_q <= S_RDY;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end

    assign xfer_cnt_o[i*16 +: 16]       = xcnt_q;
    assign csum_o[i*DATA_W +: DATA_W]   = csum_q;
  end

endmodule

// File: tb/tb_bp_sink_mc.sv
module tb_bp_sink_mc;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic [2:0]  max_stall;
  logic        clear;
  logic [63:0] xfer_cnt;
  logic [31:0] csum;

  bp_sink_mc_if #(.NUM_CH(4), .DATA_W(8)) bus();

  bp_sink_mc #(.NUM_CH(4), .DATA_W(8), .STALL_W(3), .SEED(16'hACE1)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .snk_if      (bus),
    .mode_i      (mode),
    .thresh_i    (thresh),
    .max_stall_i (max_stall),
    .clear_i     (clear),
    .xfer_cnt_o  (xfer_cnt),
    .csum_o      (csum)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int ch; logic [15:0] cnt; logic [7:0] cs; } sb_t;
  sb_t sb[$];

  bit          m_stall [NCH];
  int          m_len   [NCH];
  logic [15:0] m_lfsr  [NCH];
  logic [15:0] m_cnt   [NCH];
  logic [7:0]  m_cs    [NCH];

  function automatic logic [15:0] seed_of(int i);
    logic [15:0] s;
    s = 16'hACE1 ^ 16'(i * 'h1111);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = !m_stall[i] && (mode != 2'd3);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_stall[i] = 0; m_len[i] = 0; m_lfsr[i] = seed_of(i);
      m_cnt[i] = '0; m_cs[i] = '0;
      sb.push_back('{i, 16'h0, 8'h0});
    end
  endtask

  task automatic model_edge();
    logic [3:0] r;
    logic       xf;
    int         rnd;
    int         len;
    r = m_ready();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      xf = bus.valid[i] && r[i];
      if (clear) begin
        m_cnt[i] = '0; m_cs[i] = '0;
        sb.push_back('{i, m_cnt[i], m_cs[i]});
      end else if (xf) begin
        m_cnt[i] = m_cnt[i] + 16'd1;
        m_cs[i]  = m_cs[i] + bus.data[i*8 +: 8];
        sb.push_back('{i, m_cnt[i], m_cs[i]});
      end
      if (mode == 2'd0 || mode == 2'd3) begin
        m_stall[i] = 0; m_len[i] = 0;
      end else if (m_stall[i]) begin
        if (m_len[i] == 1) begin m_stall[i] = 0; m_len[i] = 0; end
        else m_len[i] = m_len[i] - 1;
      end else if (xf && max_stall != 0) begin
        rnd = int'(m_lfsr[i][7:0]);
        if (mode == 2'd1) begin
          if (rnd > int'(thresh)) begin
            len = rnd % 8;
            if (len == 0) len = 1;
            if (len > int'(max_stall)) len = int'(max_stall);
            m_stall[i] = 1; m_len[i] = len;
          end
        end else begin
          m_stall[i] = 1; m_len[i] = int'(max_stall);
        end
      end
      m_lfsr[i] = {m_lfsr[i][14:0], ^(m_lfsr[i] & 16'hB400)};
    end
  endtask

  // One clock: inputs already driven after a negedge; compare, then advance.
  task automatic cycle();
    sb_t e;
    #1;
    chk("ready", {60'h0, bus.ready}, {60'h0, m_ready()});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_cnt",  {48'h0, xfer_cnt[e.ch*16 +: 16]}, {48'h0, e.cnt});
      chk("sb_csum", {56'h0, csum[e.ch*8 +: 8]},       {56'h0, e.cs});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic preclear();
    mode = 2'd0; bus.valid = 4'h0; clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  // ---------------- table ----------------
  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  thr;
    logic [2:0]  ms;
    logic [3:0]  vld;
    logic [7:0]  dat;
    int          cycles;
    bit          chk_cnt;
    logic [15:0] ecnt;
    logic [7:0]  ecs;
    int          stalls;   // 0 none on ch0, 1 some, 2 don't care
  } row_t;
  row_t rows[8];

  initial begin
    int          run;
    int          nstall;
    logic [10:0] pat;

    rows[0] = '{2'd0, 8'd0,   3'd0, 4'hF, 8'h01, 100,  1'b1, 16'd100,  8'h64, 2};
    rows[1] = '{2'd2, 8'd0,   3'd3, 4'h1, 8'h05, 40,   1'b1, 16'd10,   8'h32, 1};
    rows[2] = '{2'd1, 8'd255, 3'd7, 4'hF, 8'h03, 1000, 1'b1, 16'd1000, 8'hB8, 0};
    rows[3] = '{2'd1, 8'd0,   3'd7, 4'hF, 8'h07, 300,  1'b0, 16'd0,    8'h00, 1};
    rows[4] = '{2'd2, 8'd0,   3'd0, 4'hF, 8'h02, 20,   1'b1, 16'd20,   8'h28, 0};
    rows[5] = '{2'd1, 8'd0,   3'd0, 4'hF, 8'h01, 30,   1'b1, 16'd30,   8'h1E, 0};
    rows[6] = '{2'd3, 8'd0,   3'd3, 4'hF, 8'h01, 10,   1'b1, 16'd0,    8'h00, 2};
    rows[7] = '{2'd1, 8'd200, 3'd4, 4'hA, 8'h09, 200,  1'b0, 16'd0,    8'h00, 2};

    rst_n = 1'b0; mode = 2'd0; thresh = 8'd0; max_stall = 3'd0; clear = 1'b0;
    bus.valid = 4'h0; bus.data = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    #1;
    chk("reset_ready",    {60'h0, bus.ready}, 64'hF);
    chk("reset_xfer_cnt", xfer_cnt, 64'h0);
    chk("reset_csum",     {32'h0, csum}, 64'h0);
    mode = 2'd3; #1;
    chk("hold_ready", {60'h0, bus.ready}, 64'h0);
    mode = 2'd0;
    @(negedge clk);
    model_edge();
    sb.delete();

    // ---- table-driven phases ----
    for (int r = 0; r < 8; r++) begin
      preclear();
      mode = rows[r].mode; thresh = rows[r].thr; max_stall = rows[r].ms;
      bus.valid = rows[r].vld; bus.data = {4{rows[r].dat}};
      run = 0; nstall = 0;
      for (int c = 0; c < rows[r].cycles; c++) begin
        #1;
        if (rows[r].vld[0] && (rows[r].mode == 2'd1 || rows[r].mode == 2'd2)) begin
          if (!bus.ready[0]) run++;
          else if (run > 0) begin
            nstall++;
            chk("stall_len_in_range", {63'h0, (run >= 1 && run <= int'(rows[r].ms))}, 64'h1);
            run = 0;
          end
        end
        cycle();
      end
      if (rows[r].stalls != 2)
        chk("stalls_seen", {63'h0, (nstall > 0)}, {63'h0, rows[r].stalls == 1});
      for (int ch = 0; ch < NCH; ch++) begin
        if (!rows[r].vld[ch]) begin
          chk("idle_cnt",  {48'h0, xfer_cnt[ch*16 +: 16]}, 64'h0);
          chk("idle_csum", {56'h0, csum[ch*8 +: 8]},       64'h0);
        end else if (rows[r].chk_cnt) begin
          chk("row_cnt",  {48'h0, xfer_cnt[ch*16 +: 16]}, {48'h0, rows[r].ecnt});
          chk("row_csum", {56'h0, csum[ch*8 +: 8]},       {56'h0, rows[r].ecs});
        end
      end
    end

    // ---- FIXED stall interrupted by HOLD, then ALWAYS ----
    preclear();
    mode = 2'd2; max_stall = 3'd5; bus.valid = 4'h1; bus.data = 32'h0;
    cycle();
    #1 chk("fixed_stall1", {60'h0, bus.ready}, 64'hE);
    cycle();
    mode = 2'd3;
    for (int k = 0; k < 4; k++) begin
      #1 chk("hold_mid_stall", {60'h0, bus.ready}, 64'h0);
      cycle();
    end
    mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("always_after_hold", {60'h0, bus.ready}, 64'hF);
      cycle();
    end

    // ---- clear coincident with a ch1 transfer ----
    preclear();
    mode = 2'd0; bus.valid = 4'h2; bus.data = {4{8'h11}};
    for (int k = 0; k < 20; k++) cycle();
    chk("ch1_cnt_20",  {48'h0, xfer_cnt[31:16]}, 64'd20);
    chk("ch1_csum_20", {56'h0, csum[15:8]},      64'h54);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("ch1_cnt_clr",  {48'h0, xfer_cnt[31:16]}, 64'd0);
    chk("ch1_csum_clr", {56'h0, csum[15:8]},      64'h0);
    cycle();
    chk("ch1_cnt_after",  {48'h0, xfer_cnt[31:16]}, 64'd1);
    chk("ch1_csum_after", {56'h0, csum[15:8]},      64'h11);
    chk("ch0_untouched",  {48'h0, xfer_cnt[15:0]},  64'd0);

    // ---- reset during a 7-cycle FIXED stall ----
    preclear();
    mode = 2'd2; max_stall = 3'd7; bus.valid = 4'h1; bus.data = {4{8'h3C}};
    cycle();
    for (int k = 0; k < 3; k++) begin
      #1 chk("fixed7_stall", {60'h0, bus.ready}, 64'hE);
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; mode = 2'd1; thresh = 8'd0; max_stall = 3'd7;
    #1;
    chk("post_reset_ready", {60'h0, bus.ready}, 64'hF);
    chk("post_reset_cnt",   xfer_cnt, 64'h0);
    chk("post_reset_csum",  {32'h0, csum}, 64'h0);
    for (int k = 0; k < 11; k++) begin
      #1 pat[k] = bus.ready[0];
      cycle();
    end
    // Seed ACE1: rand E1 -> 1-cycle stall, then rand 87 -> 7-cycle stall.
    chk("post_reset_lfsr_pattern", {53'h0, pat}, 64'h405);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
